// File: rtl/img_proc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : img_proc_pkg
// Description : Shared types and constants for the BMP streaming accelerator.
//               Holds the per-byte colour operation encoding, the owner
//               encoding of the stream arbiter and the BMP header offsets.
// Revision    : 1.0 - initial release
// ============================================================================
package img_proc_pkg;

    localparam int COLOR_SIZE = 8;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_BRIGHT = 2'b01,
        MODE_THRESH = 2'b10,
        MODE_INVERT = 2'b11
    } mode_e;

    // Owner of the master port; values double as the output source tag.
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_SLV0 = 2'b01,
        OWN_SLV1 = 2'b10
    } owner_e;

    // BMP header byte offsets
    localparam int FSIZE_OFS  = 2;   // 32-bit file size, little-endian
    localparam int DSTART_OFS = 10;  // 32-bit pixel data offset
    localparam int HDR_MIN    = 14;  // bytes always treated as header

endpackage
`default_nettype wire

// File: rtl/pixel_byte_op.sv
`default_nettype none
// ============================================================================
// Module      : pixel_byte_op
// Description : Combinational per-byte colour operation.
//   mode   in  2           operation select (pass/bright/thresh/invert)
//   v      in  COLOR_SIZE  operand
//   p      in  COLOR_SIZE  pixel byte
//   result out COLOR_SIZE  processed byte
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_byte_op
    import img_proc_pkg::*;
(
    input  logic [1:0]            mode,
    input  logic [COLOR_SIZE-1:0] v,
    input  logic [COLOR_SIZE-1:0] p,
    output logic [COLOR_SIZE-1:0] result
);

    logic [COLOR_SIZE:0] w_sum;

    always_comb begin
        w_sum  = {1'b0, p} + {1'b0, v};
        result = p;
        case (mode_e'(mode))
            MODE_PASS:   result = p;
            // carry out means the sum exceeded 255: clamp
            MODE_BRIGHT: result = w_sum[COLOR_SIZE] ? '1 : w_sum[COLOR_SIZE-1:0];
            MODE_THRESH: result = (p >= v) ? '1 : '0;
            MODE_INVERT: result = ~p;
            default:     result = p;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/image_processing_accelerator.sv
`default_nettype none
// ============================================================================
// Module      : image_processing_accelerator
// Description : Streams a BMP file from one of two slave inputs to a single
//               master output. Header bytes pass unchanged, pixel bytes get
//               the colour operation latched on the first beat of the file.
//   clk, rst_n              clock, synchronous active-high reset
//   slvX_mode/proc_val      operation select and operand (latched per file)
//   slvX_data_valid/data    input beat, byte k on [8k+7:8k]
//   slvX_ready              input beat accepted this cycle
//   mstr0_data/data_valid   registered output beat, one-hot source tag
//   mstr0_ready             downstream accepts output beat
//   mstr0_cmplt             set with the last beat of a file
// Revision    : 1.0 - initial release
// ============================================================================
module image_processing_accelerator
    import img_proc_pkg::*;
#(
    parameter int DATA_WIDTH = 32
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            slv0_mode,
    input  logic                  slv0_data_valid,
    input  logic [COLOR_SIZE-1:0] slv0_proc_val,
    input  logic [DATA_WIDTH-1:0] slv0_data,
    output logic                  slv0_ready,
    input  logic [1:0]            slv1_mode,
    input  logic                  slv1_data_valid,
    input  logic [COLOR_SIZE-1:0] slv1_proc_val,
    input  logic [DATA_WIDTH-1:0] slv1_data,
    output logic                  slv1_ready,
    output logic                  mstr0_cmplt,
    input  logic                  mstr0_ready,
    output logic [DATA_WIDTH-1:0] mstr0_data,
    output logic [1:0]            mstr0_data_valid
);

    localparam int NB = DATA_WIDTH / 8;

    owner_e                r_owner;
    logic [31:0]           r_idx;
    logic [31:0]           r_fsize;
    logic [31:0]           r_dstart;
    logic [1:0]            r_mode;
    logic [COLOR_SIZE-1:0] r_val;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [1:0]            r_out_tag;
    logic                  r_cmplt;

    logic                  w_idle;
    logic                  w_sel1;
    logic                  w_open;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_data;
    logic [DATA_WIDTH-1:0] w_out;
    logic [1:0]            w_mode;
    logic [COLOR_SIZE-1:0] w_val;
    logic [31:0]           w_fsize;
    logic [31:0]           w_dstart;
    logic [31:0]           w_fsize_eff;
    logic [32:0]           w_idx_next;
    logic                  w_last;

    assign w_idle = (r_owner == OWN_NONE);
    // slv1 is selected when it owns the port, or at idle when slv0 is silent
    assign w_sel1 = (r_owner == OWN_SLV1) || (w_idle && !slv0_data_valid);
    // Once the last beat is captured the owner may send nothing more until
    // the completion beat leaves, so a following file cannot merge into it.
    assign w_open = !rst_n && !r_cmplt && ((r_out_tag == 2'b00) || mstr0_ready);

    assign slv0_ready = w_open && ((r_owner == OWN_SLV0) || (w_idle && slv0_data_valid));
    assign slv1_ready = w_open && ((r_owner == OWN_SLV1) || (w_idle && !slv0_data_valid));

    assign w_accept = w_sel1 ? (slv1_data_valid && slv1_ready)
                             : (slv0_data_valid && slv0_ready);
    assign w_data   = w_sel1 ? slv1_data : slv0_data;
    // The first beat of a file uses the live operation, later beats the latch.
    assign w_mode   = w_idle ? (w_sel1 ? slv1_mode : slv0_mode) : r_mode;
    assign w_val    = w_idle ? (w_sel1 ? slv1_proc_val : slv0_proc_val) : r_val;

    // Header fields may arrive in the same beat as the bytes they classify,
    // so overlay the current beat onto the captured values.
    always_comb begin
        w_fsize  = r_fsize;
        w_dstart = r_dstart;
        for (int k = 0; k < NB; k++) begin
            for (int b = 0; b < 4; b++) begin
                if (r_idx + 32'(k) == 32'(FSIZE_OFS + b))
                    w_fsize[8*b +: 8] = w_data[8*k +: 8];
                if (r_idx + 32'(k) == 32'(DSTART_OFS + b))
                    w_dstart[8*b +: 8] = w_data[8*k +: 8];
            end
        end
    end

    // A file never ends before the fixed header has been covered.
    assign w_fsize_eff = (w_fsize < 32'(HDR_MIN)) ? 32'(HDR_MIN) : w_fsize;
    assign w_idx_next  = {1'b0, r_idx} + 33'(NB);
    // The size field is complete only once byte FSIZE_OFS+3 has been seen.
    assign w_last      = (w_idx_next >= 33'(FSIZE_OFS + 4)) &&
                         (w_idx_next >= {1'b0, w_fsize_eff});

    for (genvar k = 0; k < NB; k++) begin : g_lane
        logic [31:0]           w_pos;
        logic                  w_pix;
        logic [COLOR_SIZE-1:0] w_res;

        assign w_pos = r_idx + 32'(k);
        assign w_pix = (w_pos >= 32'(HDR_MIN)) && (w_pos >= w_dstart) && (w_pos < w_fsize);

        pixel_byte_op u_op (
            .mode   (w_mode),
            .v      (w_val),
            .p      (w_data[8*k +: 8]),
            .result (w_res)
        );

        assign w_out[8*k +: 8] = w_pix ? w_res : w_data[8*k +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_owner    <= OWN_NONE;
            r_idx      <= '0;
            r_fsize    <= '0;
            r_dstart   <= '0;
            r_mode     <= '0;
            r_val      <= '0;
            r_out_data <= '0;
            r_out_tag  <= 2'b00;
            r_cmplt    <= 1'b0;
        end else if (r_cmplt && mstr0_ready) begin
            // completion beat taken: release the port for fresh arbitration
            r_owner   <= OWN_NONE;
            r_idx     <= '0;
            r_fsize   <= '0;
            r_dstart  <= '0;
            r_out_tag <= 2'b00;
            r_cmplt   <= 1'b0;
        end else if (w_accept) begin
            if (w_idle) begin
                r_owner <= w_sel1 ? OWN_SLV1 : OWN_SLV0;
                r_mode  <= w_mode;
                r_val   <= w_val;
            end
            r_idx      <= w_idx_next[31:0];
            r_fsize    <= w_fsize;
            r_dstart   <= w_dstart;
            r_out_data <= w_out;
            r_out_tag  <= w_sel1 ? 2'b10 : 2'b01;
            r_cmplt    <= w_last;
        end else if (mstr0_ready) begin
            r_out_tag <= 2'b00;
        end
    end

    assign mstr0_data       = r_out_data;
    assign mstr0_data_valid = r_out_tag;
    assign mstr0_cmplt      = r_cmplt;

endmodule
`default_nettype wire

// File: tb/tb_image_processing_accelerator.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_processing_accelerator
// Description : Self-checking bench. Drivers push the reference-model result
//               of every accepted beat into a per-source queue; a monitor
//               pops and compares whatever the master port presents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_processing_accelerator;
    import img_proc_pkg::*;

    localparam int DW = 32;
    localparam int NB = DW / 8;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [DW-1:0] data;
        logic          cmplt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [1:0]    slv0_mode = '0, slv1_mode = '0;
    logic          slv0_data_valid = 1'b0, slv1_data_valid = 1'b0;
    logic [7:0]    slv0_proc_val = '0, slv1_proc_val = '0;
    logic [DW-1:0] slv0_data = '0, slv1_data = '0;
    logic          slv0_ready, slv1_ready;
    logic          mstr0_cmplt;
    logic          mstr0_ready = 1'b1;
    logic [DW-1:0] mstr0_data;
    logic [1:0]    mstr0_data_valid;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q0[$];
    exp_t exp_q1[$];
    logic [1:0] cmplt_tags[$];
    int   stall_cycles = 0;
    bit   random_bp = 1'b0;

    always #5 clk = ~clk;

    image_processing_accelerator #(.DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .slv0_mode        (slv0_mode),
        .slv0_data_valid  (slv0_data_valid),
        .slv0_proc_val    (slv0_proc_val),
        .slv0_data        (slv0_data),
        .slv0_ready       (slv0_ready),
        .slv1_mode        (slv1_mode),
        .slv1_data_valid  (slv1_data_valid),
        .slv1_proc_val    (slv1_proc_val),
        .slv1_data        (slv1_data),
        .slv1_ready       (slv1_ready),
        .mstr0_cmplt      (mstr0_cmplt),
        .mstr0_ready      (mstr0_ready),
        .mstr0_data       (mstr0_data),
        .mstr0_data_valid (mstr0_data_valid)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference colour operation, straight from the arithmetic rules.
    function automatic logic [7:0] ref_op(input int mode, input int v, input int p);
        case (mode)
            0:       return 8'(p);
            1:       return (p + v > 255) ? 8'd255 : 8'(p + v);
            2:       return (p >= v) ? 8'd255 : 8'd0;
            default: return 8'(255 - p);
        endcase
    endfunction

    // Random file body, header fields written in; length is whole beats
    // covering max(fsize, 14) bytes.
    function automatic bq_t make_file(input int fsize, input int dstart);
        bq_t f;
        int  len;
        len = (((fsize < 14) ? 14 : fsize) + NB - 1) / NB * NB;
        for (int i = 0; i < len; i++) f.push_back(8'($urandom));
        for (int b = 0; b < 4; b++) begin
            f[2 + b]  = 8'(fsize >> (8 * b));
            f[10 + b] = 8'(dstart >> (8 * b));
        end
        return f;
    endfunction

    task automatic drive(input int src, input logic vld, input logic [DW-1:0] d,
                         input int mode, input int v);
        if (src == 0) begin
            slv0_data_valid = vld; slv0_data = d;
            slv0_mode = 2'(mode);  slv0_proc_val = 8'(v);
        end else begin
            slv1_data_valid = vld; slv1_data = d;
            slv1_mode = 2'(mode);  slv1_proc_val = 8'(v);
        end
    endtask

    // Sends up to max_beats beats of file f on source src.
    task automatic send_file(input int src, input bq_t f, input int mode,
                             input int v, input int max_beats, input bit gaps);
        int nbeats, fs, ds, idx, wait_cnt;
        bit done;
        logic [DW-1:0] w, e;
        exp_t ex;
        nbeats = f.size() / NB;
        fs = {f[5], f[4], f[3], f[2]};
        ds = {f[13], f[12], f[11], f[10]};
        for (int b = 0; b < nbeats && b < max_beats; b++) begin
            for (int k = 0; k < NB; k++) begin
                idx = b * NB + k;
                w[8*k +: 8] = f[idx];
                if (idx >= 14 && idx >= ds && idx < fs)
                    e[8*k +: 8] = ref_op(mode, v, int'(f[idx]));
                else
                    e[8*k +: 8] = f[idx];
            end
            if (gaps && b > 0) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    drive(src, 1'b0, w, $urandom_range(0, 3), $urandom_range(0, 255));
                end
            end
            done = 1'b0;
            wait_cnt = 0;
            while (!done) begin
                @(negedge clk);
                // after the first beat the operation inputs wander freely
                if (b == 0) drive(src, 1'b1, w, mode, v);
                else        drive(src, 1'b1, w, $urandom_range(0, 3), $urandom_range(0, 255));
                #4;
                if ((src == 0) ? slv0_ready : slv1_ready) done = 1'b1;
                else if (++wait_cnt > 2000) begin
                    checks++;
                    errors++;
                    $display("FAIL ready_timeout: src %0d beat %0d never accepted, expected acceptance", src, b);
                    @(negedge clk);
                    drive(src, 1'b0, '0, 0, 0);
                    return;
                end
            end
            ex.data  = e;
            ex.cmplt = (b == nbeats - 1);
            if (src == 0) exp_q0.push_back(ex);
            else          exp_q1.push_back(ex);
        end
        @(negedge clk);
        drive(src, 1'b0, '0, 0, 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check("drain_pending", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
        repeat (2) @(posedge clk);
    endtask

    // Monitor: pops expected beats whenever the master port transfers.
    initial begin : monitor
        logic [DW-1:0] hold_data;
        logic [1:0]    hold_tag, cur_tag;
        logic          hold_c;
        bit            holding;
        exp_t          ex;
        holding = 1'b0;
        cur_tag = 2'b00;
        hold_data = '0; hold_tag = '0; hold_c = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                mstr0_ready = 1'b1;
                holding = 1'b0;
                cur_tag = 2'b00;
                continue;
            end
            if (stall_cycles > 0) begin
                mstr0_ready = 1'b0;
                stall_cycles--;
            end else begin
                mstr0_ready = random_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            #4;
            if (holding) begin
                check("hold_data",  64'(mstr0_data), 64'(hold_data));
                check("hold_tag",   64'(mstr0_data_valid), 64'(hold_tag));
                check("hold_cmplt", 64'(mstr0_cmplt), 64'(hold_c));
            end
            holding = 1'b0;
            if (mstr0_data_valid != 2'b00) begin
                if (!mstr0_ready) begin
                    check("ready_in_stall", 64'({slv0_ready, slv1_ready}), 64'd0);
                    holding   = 1'b1;
                    hold_data = mstr0_data;
                    hold_tag  = mstr0_data_valid;
                    hold_c    = mstr0_cmplt;
                end else begin
                    if (cur_tag != 2'b00)
                        check("owner_kept", 64'(mstr0_data_valid), 64'(cur_tag));
                    if (mstr0_data_valid == 2'b01 && exp_q0.size() != 0) begin
                        ex = exp_q0.pop_front();
                    end else if (mstr0_data_valid == 2'b10 && exp_q1.size() != 0) begin
                        ex = exp_q1.pop_front();
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: tag %b data %h, expected no beat", mstr0_data_valid, mstr0_data);
                        continue;
                    end
                    check("out_data",  64'(mstr0_data), 64'(ex.data));
                    check("out_cmplt", 64'(mstr0_cmplt), 64'(ex.cmplt));
                    cur_tag = mstr0_cmplt ? 2'b00 : mstr0_data_valid;
                    if (mstr0_cmplt) cmplt_tags.push_back(mstr0_data_valid);
                end
            end else begin
                check("idle_cmplt", 64'(mstr0_cmplt), 64'd0);
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bq_t f, g;
        logic [DW-1:0] wd;
        int fs, ds;

        // Reset: slv0 offers data, which must not be accepted during reset
        slv0_data_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_slv0_ready", 64'(slv0_ready), 64'd0);
        check("rst_slv1_ready", 64'(slv1_ready), 64'd0);
        check("rst_valid",      64'(mstr0_data_valid), 64'd0);
        check("rst_data",       64'(mstr0_data), 64'd0);
        check("rst_cmplt",      64'(mstr0_cmplt), 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #4;
        check("rel_slv0_ready", 64'(slv0_ready), 64'd1);
        check("rel_slv1_ready", 64'(slv1_ready), 64'd0);
        slv0_data_valid = 1'b0;
        repeat (2) @(posedge clk);

        // Pass-through, 62 bytes, data at 54: 16 beats
        f = make_file(62, 54);
        send_file(0, f, 0, 8'h55, 1000, 1'b0);
        drain();

        // Brightness with a known pixel word
        f = make_file(70, 54);
        wd = 32'hF0E01000;
        for (int k = 0; k < NB; k++) f[56 + k] = wd[8*k +: 8];
        send_file(0, f, 1, 8'h20, 1000, 1'b0);
        drain();

        // Threshold and invert on the same pixel word
        wd = 32'h7F80FF00;
        f = make_file(64, 54);
        for (int k = 0; k < NB; k++) f[56 + k] = wd[8*k +: 8];
        send_file(1, f, 2, 8'h80, 1000, 1'b0);
        drain();
        send_file(0, f, 3, 8'h12, 1000, 1'b0);
        drain();

        // Backpressure mid-file
        f = make_file(100, 54);
        fork
            send_file(0, f, 1, 8'h33, 1000, 1'b0);
            begin
                repeat (10) @(posedge clk);
                stall_cycles = 3;
            end
        join
        drain();

        // Both valid at idle: slv0 file first, then slv1
        f = make_file(40, 30);
        g = make_file(36, 20);
        cmplt_tags.delete();
        fork
            send_file(0, f, 3, 0, 1000, 1'b0);
            send_file(1, g, 2, 8'h90, 1000, 1'b0);
        join
        drain();
        check("arb_count", 64'(cmplt_tags.size()), 64'd2);
        if (cmplt_tags.size() == 2) begin
            check("arb_first",  64'(cmplt_tags[0]), 64'd1);
            check("arb_second", 64'(cmplt_tags[1]), 64'd2);
        end

        // Reset in the middle of a file, then a fresh file parses from byte 0
        f = make_file(80, 60);
        send_file(1, f, 3, 0, 7, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_valid", 64'(mstr0_data_valid), 64'd0);
        check("mid_rst_data",  64'(mstr0_data), 64'd0);
        check("mid_rst_cmplt", 64'(mstr0_cmplt), 64'd0);
        exp_q0.delete();
        exp_q1.delete();
        @(negedge clk);
        rst_n = 1'b0;
        f = make_file(50, 16);
        send_file(1, f, 1, 8'hC0, 1000, 1'b0);
        drain();

        // Randomized files, random backpressure, degenerate sizes included
        random_bp = 1'b1;
        for (int it = 0; it < 16; it++) begin
            fs = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 13)) : int'($urandom_range(14, 120));
            ds = $urandom_range(0, fs + 8);
            f = make_file(fs, ds);
            if (it % 2 == 1) begin
                g = make_file($urandom_range(14, 90), $urandom_range(0, 60));
                fork
                    send_file(0, f, $urandom_range(0, 3), $urandom_range(0, 255), 1000, 1'b1);
                    send_file(1, g, $urandom_range(0, 3), $urandom_range(0, 255), 1000, 1'b1);
                join
            end else begin
                send_file($urandom_range(0, 1), f, $urandom_range(0, 3), $urandom_range(0, 255), 1000, 1'b1);
            end
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/image_processing_accelerator.md
Name: image_processing_accelerator

Overview:
- Streaming BMP pixel processor between two slave input streams (slv0, slv1) and one master output stream (mstr0).
- Each slave delivers a complete BMP file, DATA_WIDTH bits per beat, bytes little-endian within the word.
- The block parses the BMP header, passes header bytes through unchanged and applies a per-byte colour operation, selected by mode, to pixel bytes.
- It signals completion when the whole file has been emitted.

Parameters:
- DATA_WIDTH, 32, stream word width in bits; must be a multiple of 8.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-high reset; the name is kept for codebase consistency and the polarity is fixed high-active.
- slv0_mode  in  2  operation select for stream 0.
- slv0_data_valid  in  1  slv0_data is valid.
- slv0_proc_val  in  COLOR_SIZE  operand for the operation.
- slv0_data  in  DATA_WIDTH  file bytes; byte k of the beat is on [8k+7:8k].
- slv0_ready  out  1  block accepts a slv0 beat this cycle.
- slv1_mode, slv1_data_valid, slv1_proc_val, slv1_data, slv1_ready: same as slv0, for stream 1.
- mstr0_cmplt  out  1  one-cycle pulse coincident with the last output beat of a file.
- mstr0_ready  in  1  downstream accepts an output beat.
- mstr0_data  out  DATA_WIDTH  processed bytes, same byte order as input.
- mstr0_data_valid  out  2  one-hot source tag: 01 = beat from slv0, 10 = beat from slv1, 00 = no valid data.

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - slvX_ready=0, mstr0_data_valid=00, mstr0_data=0, mstr0_cmplt=0.
  - Owner cleared, byte counters cleared.
  - Any file in progress is abandoned; nothing is flushed.
- Arbitration:
  - When idle, slv0 wins if slv0_data_valid=1, else slv1.
  - The owner keeps the master until its file completes.
  - A non-owner's ready is 0.
- Accept:
  - slvX_ready = owner-or-idle-winner AND (output register empty OR mstr0_ready).
  - A beat transfers when valid && ready.
- Latching: on the first beat of a file, mode and proc_val are latched for the whole file; later changes are ignored.
- Latency: one cycle, input beat to registered output beat.
- Output hold: output stays stable while mstr0_data_valid!=00 and mstr0_ready=0.
- Header parse (per-file byte counter idx, starting at 0):
  - file_size = bytes 2..5 (little-endian, 32 bit).
  - data_start = bytes 10..13.
  - Bytes with idx<14, or idx<data_start, are header and pass through unmodified.
- Pixel operation (applied to each byte with idx>=data_start), p = byte, v = proc_val:
  - mode 00: pass-through.
  - mode 01: brightness, min(p+v, 255) (saturating).
  - mode 10: threshold, (p>=v) ? 255 : 0.
  - mode 11: invert, 255-p (v ignored).
- Completion:
  - idx advances by DATA_WIDTH/8 per accepted beat.
  - The beat during which idx reaches or exceeds file_size is the last beat.
  - Byte lanes beyond file_size in that beat are passed through unmodified.
  - mstr0_cmplt=1 for the same cycle that beat is first presented and held with it until accepted.
  - On acceptance the owner is released and counters cleared.
  - Next idle cycle: arbitration again.
- Degenerate file: file_size<14 (known after byte 5) → the file ends at the beat covering byte 13; cmplt is pulsed there.
- Simultaneous events:
  - Both slaves valid while idle → slv0 wins.
  - New slv0 beat in the same cycle cmplt is accepted for slv1 → waits one cycle (arbitration only when idle).

Decomposition:
- Shared package img_proc_pkg: COLOR_SIZE=8; mode enum {MODE_PASS=2'b00, MODE_BRIGHT=2'b01, MODE_THRESH=2'b10, MODE_INVERT=2'b11}; BMP header offsets (FSIZE_OFS=2, DSTART_OFS=10, HDR_MIN=14).
- Sub-module pixel_byte_op: combinational (mode, v, p) → result; instantiated DATA_WIDTH/8 times.
- Top module: arbiter, header parser/counter and output register.

Test Plan:
- Reset: hold rst_n=1 for 2 cycles → all outputs 0; release → slv0_ready=1 with mstr0_ready=1.
- Pass-through: slv0 mode 00, 62-byte file with data_start=54 → mstr0_data equals input every beat, tag 01, cmplt on beat 16 only.
- Brightness: mode 01, v=0x20, pixel word 0xF0E01000 → output 0xFFFF3020; header words unchanged.
- Threshold and invert:
  - Mode 10, v=0x80, pixel word 0x7F80FF00 → 0x00FFFF00.
  - Mode 11, same word → 0x807F00FF.
- Backpressure: drop mstr0_ready for 3 cycles mid-file → output word stable, slv0_ready=0, no byte lost or duplicated.
- Arbitration:
  - Both valid at idle → slv0 file completes first (tag 01), then slv1 (tag 10).
  - Reset asserted mid-file → outputs cleared, next file parses header from byte 0.
